// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - byte-serial instruction fetch controller with valid/ready output
//
// Assembles 32-bit little-endian instructions from an 8-bit instruction memory
// read port, one byte per cycle, and presents them with a valid/ready handshake.
//
// Optional build macro: FETCH_TRACE_EN prints "pc: <inst_pc> inst: <inst_data>"
// on every accepted instruction; port behaviour is identical with or without it.
//
// Ports:
//   clk            rising-edge clock
//   rst_n          synchronous active-low reset
//   run            fetch enable; a low level only stops the block after a handshake
//   mem_addr       byte address to the imem read port
//   mem_rdata      imem byte at mem_addr, combinational
//   redirect_valid load a new (word-aligned) pc this cycle
//   redirect_pc    redirect target; low two bits are dropped
//   inst_valid     assembled instruction available (state HOLD)
//   inst_ready     consumer accepts the instruction
//   inst_data      assembled instruction, little-endian
//   inst_pc        byte address of inst_data
//   misalign_err   one-cycle pulse after a redirect with redirect_pc[1:0] != 0
//   busy           high while in state FETCH
//   inst_count     number of accepted instructions, wraps at 16 bits

module fetch_ctrl #(
    parameter int                ADDR_W   = 10,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [31:0]       inst_data,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              misalign_err,
    output logic              busy,
    output logic [15:0]       inst_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [1:0]        byte_cnt_q;
    logic [31:0]       data_q;
    logic [ADDR_W-1:0] inst_pc_q;
    logic              valid_q;
    logic              busy_q;
    logic              misalign_q;
    logic [15:0]       count_q;

    logic [ADDR_W-1:0] pc_d;
    logic [15:0]       count_d;
    logic [ADDR_W-1:0] redirect_aligned;
    logic              handshake;

    // Natural ADDR_W-bit overflow gives the 0x3FC -> 0x000 wrap.
    assign pc_d             = pc_q + ADDR_W'(4);
    assign count_d          = count_q + 16'd1;
    assign redirect_aligned = {redirect_pc[ADDR_W-1:2], 2'b00};
    assign handshake        = valid_q & inst_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            byte_cnt_q <= 2'd0;
            data_q     <= 32'd0;
            inst_pc_q  <= RESET_PC;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            misalign_q <= 1'b0;
            count_q    <= 16'd0;
        end else begin
            misalign_q <= redirect_valid && (redirect_pc[1:0] != 2'b00);

            // A handshake always counts, even when a redirect wins the pc.
            if (handshake) begin
                count_q <= count_d;
            end

            if (redirect_valid) begin
                pc_q       <= redirect_aligned;
                byte_cnt_q <= 2'd0;
                valid_q    <= 1'b0;
                if (run) begin
                    state_q <= FETCH;
                    busy_q  <= 1'b1;
                end else begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            end else begin
                case (state_q)
                    IDLE: begin
                        if (run) begin
                            state_q    <= FETCH;
                            busy_q     <= 1'b1;
                            byte_cnt_q <= 2'd0;
                        end
                    end
                    FETCH: begin
                        // run is deliberately ignored here: a started fetch always completes.
                        data_q[{byte_cnt_q, 3'b000} +: 8] <= mem_rdata;
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        if (byte_cnt_q == 2'd3) begin
                            state_q   <= HOLD;
                            busy_q    <= 1'b0;
                            valid_q   <= 1'b1;
                            inst_pc_q <= pc_q;
                        end
                    end
                    HOLD: begin
                        if (inst_ready) begin
                            valid_q    <= 1'b0;
                            pc_q       <= pc_d;
                            byte_cnt_q <= 2'd0;
                            if (run) begin
                                state_q <= FETCH;
                                busy_q  <= 1'b1;
                            end else begin
                                state_q <= IDLE;
                            end
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        valid_q <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef FETCH_TRACE_EN
    always_ff @(posedge clk) begin
        if (rst_n && handshake) begin
            $display("pc: %08h inst: %08h", 32'(inst_pc_q), data_q);
        end
    end
`else
`endif

    assign mem_addr     = (state_q == FETCH) ? {pc_q[ADDR_W-1:2], byte_cnt_q}
                                             : {pc_q[ADDR_W-1:2], 2'b00};
    assign inst_valid   = valid_q;
    assign inst_data    = data_q;
    assign inst_pc      = inst_pc_q;
    assign misalign_err = misalign_q;
    assign busy         = busy_q;
    assign inst_count   = count_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - self-checking bench for fetch_ctrl against a transaction-level model
module tb_fetch_ctrl;

    localparam int AW = 10;
    localparam int M_IDLE = 0;
    localparam int M_FETCH = 1;
    localparam int M_HOLD = 2;

    logic          clk;
    logic          rst_n;
    logic          run;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_rdata;
    logic          redirect_valid;
    logic [AW-1:0] redirect_pc;
    logic          inst_valid;
    logic          inst_ready;
    logic [31:0]   inst_data;
    logic [AW-1:0] inst_pc;
    logic          misalign_err;
    logic          busy;
    logic [15:0]   inst_count;

    logic [7:0] mem [0:1023];

    int n_cmp;
    int n_fail;

    // Transaction-level model: mode, cycles left in the fetch, pc, counters.
    int          m_mode;
    int          m_left;
    int          m_pc;
    int          m_count;
    bit          m_mis;
    bit          m_known;
    logic [31:0] m_data;
    int          m_ipc;

    fetch_ctrl #(.ADDR_W(AW), .RESET_PC('0)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .run            (run),
        .mem_addr       (mem_addr),
        .mem_rdata      (mem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .misalign_err   (misalign_err),
        .busy           (busy),
        .inst_count     (inst_count)
    );

    assign mem_rdata = mem[mem_addr];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] word_at(int pc);
        return {mem[pc + 3], mem[pc + 2], mem[pc + 1], mem[pc]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_update();
        bit hs;
        if (!rst_n) begin
            m_mode = M_IDLE; m_left = 0; m_pc = 0; m_count = 0;
            m_mis = 0; m_known = 1; m_data = 32'd0; m_ipc = 0;
        end else begin
            hs = (m_mode == M_HOLD) && inst_ready;
            if (hs) m_count = (m_count + 1) % 65536;
            m_mis = redirect_valid && (redirect_pc % 4 != 0);
            if (redirect_valid) begin
                m_pc = (redirect_pc / 4) * 4;
                m_left = 4;
                if (run) begin
                    m_mode = M_FETCH; m_known = 0;
                end else begin
                    m_mode = M_IDLE;
                end
            end else if (m_mode == M_IDLE) begin
                if (run) begin
                    m_mode = M_FETCH; m_left = 4; m_known = 0;
                end
            end else if (m_mode == M_FETCH) begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    m_mode = M_HOLD; m_known = 1;
                    m_data = word_at(m_pc); m_ipc = m_pc;
                end
            end else if (hs) begin
                m_pc = (m_pc + 4) % 1024;
                m_left = 4;
                if (run) begin
                    m_mode = M_FETCH; m_known = 0;
                end else begin
                    m_mode = M_IDLE;
                end
            end
        end
    endtask

    task automatic check_all();
        int exp_addr;
        exp_addr = (m_mode == M_FETCH) ? m_pc + (4 - m_left) : m_pc;
        chk("valid", 32'(inst_valid), 32'(m_mode == M_HOLD));
        chk("busy", 32'(busy), 32'(m_mode == M_FETCH));
        chk("misalign", 32'(misalign_err), 32'(m_mis));
        chk("count", 32'(inst_count), 32'(m_count));
        chk("mem_addr", 32'(mem_addr), 32'(exp_addr));
        if (m_known) begin
            chk("inst_data", inst_data, m_data);
            chk("inst_pc", 32'(inst_pc), 32'(m_ipc));
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        check_all();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
        mem[0] = 8'h13; mem[1] = 8'h05; mem[2] = 8'h00; mem[3] = 8'h00;
        mem[4] = 8'h93; mem[5] = 8'h05; mem[6] = 8'h10; mem[7] = 8'h00;

        rst_n = 1'b0; run = 1'b0; inst_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = '0;
        @(negedge clk);
        steps(2);
        chk("rst_valid", 32'(inst_valid), 32'd0);
        chk("rst_data", inst_data, 32'd0);
        chk("rst_pc", 32'(inst_pc), 32'd0);
        chk("rst_count", 32'(inst_count), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);

        // First two instructions from reset, ready held high.
        rst_n = 1'b1; run = 1'b1; inst_ready = 1'b1;
        step();
        chk("fetch_entry_busy", 32'(busy), 32'd1);
        steps(4);
        chk("first_data", inst_data, 32'h0000_0513);
        chk("first_pc", 32'(inst_pc), 32'h000);
        chk("first_valid", 32'(inst_valid), 32'd1);
        steps(5);
        chk("second_data", inst_data, 32'h0010_0593);
        chk("second_pc", 32'(inst_pc), 32'h004);

        // Back-pressure in HOLD.
        inst_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("hold_data", inst_data, 32'h0010_0593);
            chk("hold_pc", 32'(inst_pc), 32'h004);
            chk("hold_busy", 32'(busy), 32'd0);
            chk("hold_count", 32'(inst_count), 32'd1);
        end
        inst_ready = 1'b1;
        step();
        chk("release_count", 32'(inst_count), 32'd2);
        chk("release_addr", 32'(mem_addr), 32'h008);

        // Redirect to the top word, then wrap to zero.
        redirect_valid = 1'b1; redirect_pc = 10'h3FC;
        step();
        redirect_valid = 1'b0;
        steps(4);
        chk("top_pc", 32'(inst_pc), 32'h3FC);
        steps(5);
        chk("wrap_pc", 32'(inst_pc), 32'h000);

        // Misaligned redirect mid-fetch.
        steps(3);
        redirect_valid = 1'b1; redirect_pc = 10'h105;
        step();
        redirect_valid = 1'b0;
        chk("misalign_pulse", 32'(misalign_err), 32'd1);
        step();
        chk("misalign_clear", 32'(misalign_err), 32'd0);
        steps(3);
        chk("misalign_pc", 32'(inst_pc), 32'h104);
        chk("misalign_data", inst_data, word_at(32'h104));

        // Redirect coinciding with a handshake.
        redirect_valid = 1'b1; redirect_pc = 10'h200;
        step();
        redirect_valid = 1'b0;
        chk("redir_hs_count", 32'(inst_count), 32'd5);
        steps(4);
        chk("redir_hs_pc", 32'(inst_pc), 32'h200);

        // run drops mid-fetch: fetch completes, then idle after handshake.
        steps(2);
        run = 1'b0;
        steps(3);
        chk("run_low_valid", 32'(inst_valid), 32'd1);
        chk("run_low_pc", 32'(inst_pc), 32'h204);
        step();
        for (int i = 0; i < 3; i++) begin
            step();
            chk("idle_addr", 32'(mem_addr), 32'h208);
            chk("idle_busy", 32'(busy), 32'd0);
        end

        // Reset while holding an instruction.
        run = 1'b1;
        steps(5);
        inst_ready = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        chk("hold_rst_valid", 32'(inst_valid), 32'd0);
        chk("hold_rst_count", 32'(inst_count), 32'd0);
        rst_n = 1'b1;

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            run            = ($urandom % 8) != 0;
            inst_ready     = ($urandom % 3) != 0;
            redirect_valid = ($urandom % 20) == 0;
            redirect_pc    = AW'($urandom);
            rst_n          = ($urandom % 300) != 0;
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter: ADDR_W, 10, byte-address width of the instruction memory (1024 bytes).
REQ-002 Parameter: RESET_PC, 0, fetch start address after reset, word-aligned.
REQ-003 The block SHALL have these ports, in order. One clock; reset is synchronous and active-low.
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- run  in  1  fetch enable; low stalls at the next instruction boundary.
- mem_addr  out  ADDR_W  byte address to the imem read port.
- mem_rdata  in  8  imem byte at mem_addr, combinational same-cycle.
- redirect_valid  in  1  load a new PC this cycle.
- redirect_pc  in  ADDR_W  redirect target.
- inst_valid  out  1  assembled instruction available.
- inst_ready  in  1  consumer accepts the instruction.
- inst_data  out  32  assembled instruction, little-endian.
- inst_pc  out  ADDR_W  byte address of inst_data.
- misalign_err  out  1  one-cycle pulse on an unaligned redirect.
- busy  out  1  high while in state FETCH.
- inst_count  out  16  count of accepted instructions.

Function
REQ-004 FSM states: IDLE, FETCH, HOLD.
- IDLE -> FETCH when run=1.
- FETCH runs 4 cycles (byte_cnt 0..3), then -> HOLD.
- HOLD -> FETCH on handshake when run=1; HOLD -> IDLE on handshake when run=0.
REQ-005 mem_addr SHALL equal {pc[ADDR_W-1:2], byte_cnt} in FETCH, and {pc[ADDR_W-1:2], 2'b00} otherwise.
REQ-006 Byte k SHALL be captured into inst_data[8k+7:8k] at the clock edge ending FETCH cycle byte_cnt=k.
REQ-007 inst_valid SHALL be high exactly in HOLD; latency is 4 cycles from FETCH entry to inst_valid; one instruction per 5 cycles at most.
REQ-008 A handshake is inst_valid & inst_ready; inst_data and inst_pc SHALL stay stable in HOLD until the handshake.
REQ-009 On a handshake, pc SHALL become pc+4 modulo 2^ADDR_W (0x3FC wraps to 0x000), and inst_count SHALL increment, wrapping 0xFFFF -> 0x0000.
REQ-010 redirect_valid in any state SHALL:
- set pc to {redirect_pc[ADDR_W-1:2], 2'b00};
- abandon any partial fetch and drop inst_valid;
- enter FETCH with byte_cnt=0 next cycle if run=1, else IDLE.
REQ-011 A redirect in the same cycle as a handshake SHALL take priority for pc; the handshake SHALL still count in inst_count.
REQ-012 misalign_err SHALL pulse high for one cycle, the cycle after a redirect with redirect_pc[1:0] != 0.
REQ-013 run falling mid-FETCH SHALL NOT stop the fetch; the block SHALL stop only on a HOLD handshake.
REQ-014 inst_pc SHALL equal the pc of the fetch that produced inst_data.

Reset
REQ-015 When rst_n=0 at a rising edge:
- state=IDLE, pc=RESET_PC, byte_cnt=0;
- inst_valid=0, inst_data=0, inst_pc=RESET_PC;
- misalign_err=0, busy=0, inst_count=0.
REQ-016 Reset asserted mid-FETCH or in HOLD SHALL discard the instruction with no handshake counted; reset SHALL override redirect_valid.

Configuration
REQ-017 With macro FETCH_TRACE_EN defined, each handshake SHALL print one simulation line "pc: <inst_pc 8 hex> inst: <inst_data 8 hex>".
REQ-018 Without FETCH_TRACE_EN, the block SHALL print nothing; all port behaviour SHALL be identical in both builds.

Verification
REQ-019 Reset release, run=1, inst_ready=1, imem bytes 0..7 = 13,05,00,00,93,05,10,00:
- inst_valid rises 4 cycles after FETCH entry with inst_data=0x00000513, inst_pc=0x000;
- the next instruction is 0x00100593 at inst_pc=0x004, 5 cycles later.
REQ-020 inst_ready held 0 for 10 cycles in HOLD: inst_data and inst_pc stable, busy=0, inst_count unchanged; ready=1 gives count+1 and FETCH at pc+4.
REQ-021 Redirect to 0x3FC, then accept: next inst_pc=0x000 (wrap).
REQ-022 Misaligned redirect and redirect timing:
- redirect_pc=0x105 during FETCH byte_cnt=2: misalign_err pulses once; next inst_pc=0x104; partial bytes discarded.
- redirect and handshake in the same cycle: inst_count increments; next inst_pc = redirect target.
REQ-023 run=0 mid-FETCH: instruction completes to HOLD; after the handshake state=IDLE, mem_addr static.
REQ-024 rst_n=0 in HOLD: inst_valid=0 and inst_count=0 the next cycle.
